// File: rtl/pu_result_packer.sv
// Result packer downstream of pu: buffers 32-bit results in a FIFO and packs
// PACK consecutive words into one wide valid/ready beat. A flush request
// pushes out any partial beat with a keep mask and tags the final beat o_last.
module pu_result_packer #(
    parameter int DEPTH = 8,
    parameter int PACK  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                i_data,
    input  logic                       i_dv,
    output logic                       o_rdy,
    input  logic                       flush,
    output logic [PACK*32-1:0]         o_data,
    output logic [PACK-1:0]            o_keep,
    output logic                       o_last,
    output logic                       o_dv,
    input  logic                       i_rdy,
    output logic [15:0]                o_count,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int LW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int FCW = $clog2(PACK + 1);

    logic [31:0]    mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level, level_nxt;
    logic [31:0]    slot [PACK];
    logic [FCW-1:0] fc;
    logic           flush_pending;
    logic           rdy_en;

    logic fifo_full, fifo_empty;
    logic accept, pop, handshake;
    logic full_beat, part_beat;
    logic fp_set, fp_clr;

    // Handshake and pack-register control, all derived from registered state
    always_comb begin
        fifo_full  = (level == LW'(DEPTH));
        fifo_empty = (level == '0);
        // rdy_en keeps o_rdy low through reset and for the first cycle after it
        o_rdy      = rdy_en && !fifo_full && !flush_pending;
        accept     = i_dv && o_rdy;
        pop        = !fifo_empty && (fc < FCW'(PACK)) && !o_dv;
        handshake  = o_dv && i_rdy;
        level_nxt  = level + LW'(accept) - LW'(pop);
        full_beat  = pop && (fc == FCW'(PACK - 1));
        // pop is impossible when the FIFO is empty, so the two beat kinds are exclusive
        part_beat  = flush_pending && fifo_empty && (fc != '0) &&
                     (fc < FCW'(PACK)) && !o_dv;
        fp_set     = flush && !flush_pending;
        // Clear after the o_last beat, or when nothing at all is left to drain
        fp_clr     = (handshake && o_last) ||
                     (flush_pending && !o_dv && (fc == '0) && fifo_empty);
    end

    // Output view of the pack register; slots beyond fc are always zero
    always_comb begin
        o_data  = '0;
        o_keep  = '0;
        o_level = level;
        for (int k = 0; k < PACK; k++) begin
            o_data[32*k +: 32] = slot[k];
            o_keep[k]          = o_dv && (fc > FCW'(k));
        end
    end

    // FIFO storage, pointers, occupancy and accepted-word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            o_count <= '0;
            rdy_en  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= wr_ptr + 1'b1;
                o_count     <= o_count + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
        end
    end

    // Pack register doubles as the output register; fills slot fc on each pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PACK; k++) slot[k] <= '0;
            fc     <= '0;
            o_dv   <= 1'b0;
            o_last <= 1'b0;
        end else if (handshake) begin
            for (int k = 0; k < PACK; k++) slot[k] <= '0;
            fc     <= '0;
            o_dv   <= 1'b0;
            o_last <= 1'b0;
        end else begin
            if (pop) begin
                for (int k = 0; k < PACK; k++)
                    if (fc == FCW'(k)) slot[k] <= mem[rd_ptr];
                fc <= fc + 1'b1;
            end
            if (full_beat) begin
                o_dv <= 1'b1;
                // Last only if a flush is (or is becoming) pending and nothing remains queued
                o_last <= (flush_pending || fp_set) && (level_nxt == '0);
            end else if (part_beat) begin
                o_dv   <= 1'b1;
                o_last <= 1'b1;
            end
        end
    end

    // Flush request latch; a second request while pending is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      flush_pending <= 1'b0;
        else if (fp_clr) flush_pending <= 1'b0;
        else if (fp_set) flush_pending <= 1'b1;
    end

endmodule

// File: tb/tb_pu_result_packer.sv
// Directed bench for pu_result_packer with PACK=4, DEPTH=8.
module tb_pu_result_packer;

    localparam int DEPTH = 8;
    localparam int PACK  = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [31:0]  i_data = '0;
    logic         i_dv = 1'b0;
    logic         o_rdy;
    logic         flush = 1'b0;
    logic [127:0] o_data;
    logic [3:0]   o_keep;
    logic         o_last;
    logic         o_dv;
    logic         i_rdy = 1'b1;
    logic [15:0]  o_count;
    logic [3:0]   o_level;

    pu_result_packer #(.DEPTH(DEPTH), .PACK(PACK)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_dv(i_dv), .o_rdy(o_rdy),
        .flush(flush), .o_data(o_data), .o_keep(o_keep), .o_last(o_last),
        .o_dv(o_dv), .i_rdy(i_rdy), .o_count(o_count), .o_level(o_level)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] n; logic [31:0] base; logic fl; } stim_t;
    typedef struct packed { logic [7:0] grp; logic [127:0] d; logic [3:0] k; logic l; } beat_t;
    typedef struct packed { logic [127:0] d; logic [3:0] k; logic l; } obs_t;

    stim_t stims [5];
    beat_t beats [7];
    obs_t  q [$];

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Collect handshaken beats and verify the beat holds steady while stalled
    logic         stalled = 1'b0;
    logic [133:0] held;
    always @(negedge clk) begin
        if (!rst_n) stalled = 1'b0;
        else begin
            if (stalled) begin
                n_checks++;
                if ({o_dv, o_data, o_keep, o_last} !== held) begin
                    n_errors++;
                    $display("FAIL stall_hold: got %h expected %h", {o_dv, o_data, o_keep, o_last}, held);
                end
            end
            stalled = o_dv && !i_rdy;
            held    = {o_dv, o_data, o_keep, o_last};
            if (o_dv && i_rdy) q.push_back({o_data, o_keep, o_last});
        end
    end

    task automatic send(input logic [31:0] w);
        int t;
        t = 0;
        i_dv = 1'b1;
        i_data = w;
        @(negedge clk);
        while (!o_rdy && t < 300) begin @(negedge clk); t++; end
        if (!o_rdy) chk("send_timeout", o_rdy, 1);
        @(posedge clk); #1;
        i_dv = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (q.size() < n && t < 500) begin @(negedge clk); #1; t++; end
    endtask

    task automatic wait_rdy();
        int t;
        t = 0;
        while (!o_rdy && t < 100) begin @(negedge clk); t++; end
    endtask

    function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
        return {d[31:0], c[31:0], b[31:0], a[31:0]};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb, bi;
        logic [127:0] e;

        stims[0] = '{8'd4, 32'd1,  1'b0};
        stims[1] = '{8'd6, 32'd10, 1'b1};
        stims[2] = '{8'd4, 32'd20, 1'b1};
        stims[3] = '{8'd1, 32'd30, 1'b1};
        stims[4] = '{8'd7, 32'd40, 1'b1};
        beats[0] = '{8'd0, pk(1, 2, 3, 4),     4'b1111, 1'b0};
        beats[1] = '{8'd1, pk(10, 11, 12, 13), 4'b1111, 1'b0};
        beats[2] = '{8'd1, pk(14, 15, 0, 0),   4'b0011, 1'b1};
        beats[3] = '{8'd2, pk(20, 21, 22, 23), 4'b1111, 1'b1};
        beats[4] = '{8'd3, pk(30, 0, 0, 0),    4'b0001, 1'b1};
        beats[5] = '{8'd4, pk(40, 41, 42, 43), 4'b1111, 1'b0};
        beats[6] = '{8'd4, pk(44, 45, 46, 0),  4'b0111, 1'b1};

        // Asynchronous reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rdy", o_rdy, 0);
        chk("rst_dv", o_dv, 0);
        chk("rst_data", o_data, 0);
        chk("rst_keep", o_keep, 0);
        chk("rst_last", o_last, 0);
        chk("rst_count", o_count, 0);
        chk("rst_level", o_level, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven packing and flush sequences
        for (int g = 0; g < 5; g++) begin
            q.delete();
            for (int w = 0; w < int'(stims[g].n); w++) send(stims[g].base + w);
            exp_count += int'(stims[g].n);
            if (stims[g].fl) begin
                pulse_flush();
                @(negedge clk);
                chk($sformatf("g%0d_rdy_blocked", g), o_rdy, 0);
            end
            nb = 0;
            for (int b = 0; b < 7; b++) if (int'(beats[b].grp) == g) nb++;
            wait_beats(nb);
            repeat (3) @(negedge clk);
            wait_rdy();
            chk($sformatf("g%0d_rdy_back", g), o_rdy, 1);
            chk($sformatf("g%0d_nbeats", g), q.size(), nb);
            bi = 0;
            for (int b = 0; b < 7; b++) begin
                if (int'(beats[b].grp) == g) begin
                    if (bi < q.size()) begin
                        chk($sformatf("g%0d_b%0d_data", g, bi), q[bi].d, beats[b].d);
                        chk($sformatf("g%0d_b%0d_keep", g, bi), q[bi].k, beats[b].k);
                        chk($sformatf("g%0d_b%0d_last", g, bi), q[bi].l, beats[b].l);
                    end
                    bi++;
                end
            end
            chk($sformatf("g%0d_count", g), o_count, exp_count);
            chk($sformatf("g%0d_level", g), o_level, 0);
            @(posedge clk); #1;
        end

        // Backpressure: one stalled beat plus a full FIFO
        q.delete();
        i_rdy = 1'b0;
        for (int w = 0; w < 12; w++) send(w);
        exp_count += 12;
        i_dv = 1'b1;
        i_data = 32'd99;
        repeat (5) @(negedge clk);
        chk("full_rdy", o_rdy, 0);
        chk("full_count", o_count, exp_count);
        chk("full_level", o_level, 8);
        chk("full_dv", o_dv, 1);
        chk("full_data", o_data, pk(0, 1, 2, 3));
        i_dv = 1'b0;
        @(posedge clk); #1;
        i_rdy = 1'b1;
        wait_beats(3);
        repeat (3) @(negedge clk);
        chk("bp_nbeats", q.size(), 3);
        for (int j = 0; j < 3; j++)
            if (j < q.size()) begin
                chk($sformatf("bp_b%0d_data", j), q[j].d, pk(4*j, 4*j+1, 4*j+2, 4*j+3));
                chk($sformatf("bp_b%0d_keep", j), q[j].k, 4'b1111);
            end
        chk("bp_count", o_count, exp_count);
        @(posedge clk); #1;

        // Random downstream backpressure over 64 sequential words
        q.delete();
        fork
            begin
                for (int w = 0; w < 64; w++) send(100 + w);
            end
            begin
                for (int c = 0; c < 600; c++) begin
                    @(posedge clk); #1;
                    i_rdy = 1'($urandom_range(0, 1));
                end
            end
        join_any
        disable fork;
        exp_count += 64;
        i_rdy = 1'b1;
        wait_beats(16);
        repeat (3) @(negedge clk);
        chk("rnd_nbeats", q.size(), 16);
        for (int j = 0; j < 16; j++)
            if (j < q.size()) begin
                e = pk(100 + 4*j, 101 + 4*j, 102 + 4*j, 103 + 4*j);
                chk($sformatf("rnd_b%0d_data", j), q[j].d, e);
            end
        chk("rnd_count", o_count, exp_count);
        @(posedge clk); #1;

        // Flush with nothing buffered: no beat, ready back after two cycles
        q.delete();
        pulse_flush();
        @(negedge clk);
        chk("idle_flush_rdy_low", o_rdy, 0);
        @(negedge clk);
        chk("idle_flush_rdy_back", o_rdy, 1);
        repeat (4) @(negedge clk);
        chk("idle_flush_nobeat", q.size(), 0);
        chk("idle_flush_dv", o_dv, 0);
        @(posedge clk); #1;

        // Reset in the middle of buffered data
        i_rdy = 1'b0;
        for (int w = 0; w < 5; w++) send(50 + w);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dv", o_dv, 0);
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_keep", o_keep, 0);
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_level", o_level, 0);
        chk("mid_rst_rdy", o_rdy, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        i_rdy = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        for (int w = 7; w <= 10; w++) send(w);
        wait_beats(1);
        repeat (3) @(negedge clk);
        chk("post_rst_nbeats", q.size(), 1);
        if (q.size() > 0) begin
            chk("post_rst_data", q[0].d, pk(7, 8, 9, 10));
            chk("post_rst_keep", q[0].k, 4'b1111);
            chk("post_rst_last", q[0].l, 0);
        end
        chk("post_rst_count", o_count, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
